ped_req_scheduler: RTL and testbench
====================================

Name: ped_req_scheduler

Overview:
- Collects pedestrian push-button requests from NUM_XWALK crosswalks and drives the single ped_req input of the intersection traffic-light FSM.
- Synchronises and debounces each button, then holds one sticky pending bit per crosswalk.
- Grants exactly one crosswalk per controller walk phase, using round-robin order.
- Tracks how long the current request has waited, and flags when that wait saturates.

Parameters:
- NUM_XWALK, 4, number of crosswalk buttons (2..8)
- DEBOUNCE_CYC, 4, consecutive stable-high synchronised samples that count as one press
- MAX_WAIT, 63, saturation value of the wait counter, in cycles
- WAIT_W, 6, wait counter width; must satisfy 2^WAIT_W > MAX_WAIT

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset; clock clk
- btn  in  NUM_XWALK  raw button levels, asynchronous to clk
- ped_signal  in  1  walk-active indication from the traffic-light controller
- ped_req  out  1  pedestrian request to the controller
- walk_grant  out  NUM_XWALK  one-hot crosswalk currently allowed to walk
- pending  out  NUM_XWALK  sticky latched requests
- wait_sat  out  1  request wait counter has reached MAX_WAIT

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, rr_ptr=0, wait counter 0, synchroniser and debounce state cleared. Reset is asynchronous; an assertion mid-WALK drops the grant immediately and discards all pending requests.
- Input path: each btn bit passes through a 2-flop synchroniser, then a per-button debounce counter.
  - The counter increments while the synchronised level is 1 and clears on 0.
  - A press event is a 1-cycle pulse when the counter reaches DEBOUNCE_CYC. The counter then holds, so one press gives one event.
- Pending update: a press event sets pending[i] in the cycle after the pulse.
  - If pending[i] is already set, the event has no effect.
  - An event on the crosswalk currently granted, while in WALK, is dropped.
- FSM states: IDLE, REQ, WALK, CLEAR.
  - IDLE: ped_req=0. If pending≠0, go to REQ. If ped_signal=1 here, ignore it; no grant is issued.
  - REQ: ped_req=1 and the wait counter increments, saturating at MAX_WAIT; wait_sat=1 while at saturation. When ped_signal=1 is sampled:
    - pick the winner as the first set pending bit searching from rr_ptr upward, with wrap-around;
    - register walk_grant = onehot(winner) and go to WALK.
    - walk_grant asserts 1 cycle after ped_signal is seen.
  - WALK: ped_req=1 and walk_grant is held stable. When ped_signal=0 is sampled:
    - clear pending[winner];
    - set rr_ptr = (winner+1) mod NUM_XWALK;
    - walk_grant=0, clear the wait counter and wait_sat, go to CLEAR.
  - CLEAR: ped_req=0 for exactly 1 cycle, then go to IDLE. This keeps the controller from re-seeing a stale request.
- Simultaneous events:
  - Press event and grant clear for different bits in the same cycle: both take effect.
  - Several pending bits at grant time: only one crosswalk is served per walk phase; the rest stay pending.
- At most one walk_grant bit is ever set, and walk_grant is nonzero only in WALK.

Optional Feature:
- Macro ACCESS_PRIO_EN.
- Defined: crosswalk 0 is the accessible crossing and wins whenever pending[0]=1 at grant time. rr_ptr is not updated when crosswalk 0 wins.
- Undefined: pure round-robin as described above; no bit has priority.

Decomposition:
- Package ped_sched_pkg:
  - FSM state enum {IDLE, REQ, WALK, CLEAR};
  - default parameter constants;
  - a function for the round-robin first-set search with wrap.
- Sub-module ped_btn_debounce: 2-flop synchroniser plus debounce counter plus press pulse, instantiated NUM_XWALK times via generate.

Test Plan:
1. Reset then idle: btn=0 for 20 cycles -> ped_req=0, pending=0, walk_grant=0 throughout.
2. Debounce: btn[2] high for 3 cycles then low -> pending stays 0. btn[2] held high -> pending[2]=1 after 2 sync + 4 debounce + 1 cycles; ped_req=1 the following cycle.
3. Round-robin: pending=4'b1011, rr_ptr=0 -> three walk phases grant 0001, 0010, 1000 in that order; pending reaches 0; a CLEAR cycle with ped_req=0 follows each phase.
4. Wait saturation: hold REQ with ped_signal=0 for 70 cycles -> wait_sat=1 from cycle 63. A subsequent walk completion clears it.
5. Mid-walk reset: assert reset during WALK with pending=4'b0110 -> all outputs 0 asynchronously; after release, FSM is in IDLE with pending=0.
6. ACCESS_PRIO_EN build: pending=4'b1001, rr_ptr=3 -> grant 0001 first, then 1000; without the macro the grant order is 1000 then 0001.

Source files
------------

// File: rtl/ped_req_scheduler_pkg.sv
// Shared types, default sizing and the round-robin search used by the
// pedestrian request scheduler.
package ped_sched_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WALK, CLEAR} state_t;

    localparam int NUM_XWALK_DEF    = 4;
    localparam int DEBOUNCE_CYC_DEF = 4;
    localparam int MAX_WAIT_DEF     = 63;
    localparam int WAIT_W_DEF       = 6;

    // Widest supported crosswalk count; indices are always carried in PTR_W bits.
    localparam int MAX_XWALK = 8;
    localparam int PTR_W     = 3;

    // First set bit of req, searching upward from ptr and wrapping at n.
    function automatic logic [PTR_W-1:0] rr_first(input logic [MAX_XWALK-1:0] req,
                                                   input logic [PTR_W-1:0]     ptr,
                                                   input int                   n);
        logic [PTR_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_XWALK; i++) begin
            idx = (int'(ptr) + i) % n;
            if (!found && (i < n) && req[idx[PTR_W-1:0]]) begin
                win   = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/ped_req_scheduler_debounce.sv
// One crosswalk button: 2-flop synchroniser, stable-high debounce counter and
// a single-cycle press pulse per press.
module ped_btn_debounce
    import ped_sched_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYC);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Synchronise, count stable-high samples, pulse once when the count completes.
    // NOTE: btn is asynchronous; only sync2 may feed logic, sync1 exists to settle metastability.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            sync1 <= btn;
            sync2 <= sync1;
            if (!sync2)
                cnt <= '0;
            else if (cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
            press <= sync2 && (cnt == CNT_MAX - 1'b1);
        end
    end

endmodule

// File: rtl/ped_req_scheduler.sv
// Pedestrian request scheduler: debounces NUM_XWALK buttons, keeps sticky
// pending bits and grants one crosswalk per controller walk phase in
// round-robin order. Build option ACCESS_PRIO_EN gives crosswalk 0 absolute
// priority at grant time.
module ped_req_scheduler
    import ped_sched_pkg::*;
#(
    parameter int NUM_XWALK    = NUM_XWALK_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int MAX_WAIT     = MAX_WAIT_DEF,
    parameter int WAIT_W       = WAIT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_XWALK-1:0] btn,
    input  logic                 ped_signal,
    output logic                 ped_req,
    output logic [NUM_XWALK-1:0] walk_grant,
    output logic [NUM_XWALK-1:0] pending,
    output logic                 wait_sat
);

    localparam logic [WAIT_W-1:0]    WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [NUM_XWALK-1:0] GRANT_ONE = NUM_XWALK'(1);
    localparam logic [PTR_W-1:0]     LAST_IDX  = PTR_W'(NUM_XWALK - 1);

    state_t                 state;
    logic [NUM_XWALK-1:0]   press;
    logic [NUM_XWALK-1:0]   set_mask;
    logic [NUM_XWALK-1:0]   clr_mask;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       pick;
    logic                   pick_prio;
    logic                   prio_win;
    logic [WAIT_W-1:0]      wait_cnt;

    for (genvar g = 0; g < NUM_XWALK; g++) begin : g_btn
        ped_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
            .clk   (clk),
            .reset (reset),
            .btn   (btn[g]),
            .press (press[g])
        );
    end

    // Choose the crosswalk that would win if the walk phase started now.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        pick      = rr_first(MAX_XWALK'(pending), rr_ptr, NUM_XWALK);
        pick_prio = 1'b0;
`ifdef ACCESS_PRIO_EN
        if (pending[0]) begin
            pick      = '0;
            pick_prio = 1'b1;
        end
`endif
    end

    // New presses latch in unless they target the crosswalk walking now; the
    // served crosswalk clears as its walk phase ends.
    always_comb begin
        set_mask = press;
        clr_mask = '0;
        if (state == WALK) begin
            set_mask = press & ~walk_grant;
            if (!ped_signal)
                clr_mask = walk_grant;
        end
    end

    // Sticky pending requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pending <= '0;
        else
            pending <= (pending | set_mask) & ~clr_mask;
    end

    // Walk-phase FSM with registered request, grant and wait outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ped_req    <= 1'b0;
            walk_grant <= '0;
            wait_sat   <= 1'b0;
            wait_cnt   <= '0;
            rr_ptr     <= '0;
            grant_idx  <= '0;
            prio_win   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state   <= REQ;
                        ped_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (wait_cnt != WAIT_MAX)
                        wait_cnt <= wait_cnt + 1'b1;
                    wait_sat <= (wait_cnt >= WAIT_MAX - 1'b1);
                    if (ped_signal) begin
                        walk_grant <= GRANT_ONE << pick;
                        grant_idx  <= pick;
                        prio_win   <= pick_prio;
                        state      <= WALK;
                    end
                end
                WALK: begin
                    if (!ped_signal) begin
                        walk_grant <= '0;
                        ped_req    <= 1'b0;
                        wait_cnt   <= '0;
                        wait_sat   <= 1'b0;
                        if (!prio_win)
                            rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ped_req_scheduler.sv
// Scoreboard bench for ped_req_scheduler: a set/pointer reference model
// predicts each walk grant, a negedge monitor compares grants as they appear.
module tb_ped_req_scheduler;

    localparam int NX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NX-1:0] btn;
    logic          ped_signal;
    logic          ped_req;
    logic [NX-1:0] walk_grant;
    logic [NX-1:0] pending;
    logic          wait_sat;

    int tests = 0;
    int fails = 0;

    // Reference model: set of waiting crosswalks and next round-robin start.
    bit [NX-1:0]   m_pend;
    int            m_rr;
    logic [NX-1:0] exp_q[$];
    logic [NX-1:0] mon_prev;
    logic [NX-1:0] mon_cur;

    ped_req_scheduler #(
        .NUM_XWALK   (NX),
        .DEBOUNCE_CYC(4),
        .MAX_WAIT    (63),
        .WAIT_W      (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .ped_signal (ped_signal),
        .ped_req    (ped_req),
        .walk_grant (walk_grant),
        .pending    (pending),
        .wait_sat   (wait_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick();
`ifdef ACCESS_PRIO_EN
        if (m_pend[0]) return 0;
`endif
        for (int i = 0; i < NX; i++) begin
            if (m_pend[(m_rr + i) % NX]) return (m_rr + i) % NX;
        end
        return -1;
    endfunction

    // Grant monitor: pops an expectation each time a grant appears.
    always @(negedge clk) begin
        if (reset) begin
            mon_prev = '0;
        end else begin
            if (walk_grant != '0 && mon_prev == '0) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_grant: got %0h, expected none", walk_grant);
                end else begin
                    mon_cur = exp_q.pop_front();
                    check("walk_grant", 32'(walk_grant), 32'(mon_cur));
                end
            end else if (walk_grant != '0) begin
                check("grant_stable", 32'(walk_grant), 32'(mon_cur));
            end
            if (walk_grant != '0)
                check("grant_onehot", $countones(walk_grant), 1);
            mon_prev = walk_grant;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        m_pend = '0;
        m_rr   = 0;
    endtask

    // Wait (bounded) until the scheduler raises ped_req.
    task automatic wait_req();
        int n;
        n = 0;
        while (ped_req !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ped_req_rise", 32'(ped_req), 1);
    endtask

    // Hold buttons until every pressed bit is pending (bounded), then release.
    task automatic press_wait(input logic [NX-1:0] mask);
        int n;
        n   = 0;
        btn = mask;
        while ((pending & mask) != mask && n < 20) begin
            @(negedge clk);
            n++;
        end
        btn    = '0;
        m_pend = m_pend | mask;
        check("pending_after_press", 32'(pending), 32'(m_pend));
        @(negedge clk);
    endtask

    // One full walk phase; extra buttons are pressed while walking.
    task automatic walk(input logic [NX-1:0] walk_press);
        int            w;
        logic [NX-1:0] e;
        wait_req();
        w = model_pick();
        if (w < 0) begin
            tests++;
            fails++;
            $display("FAIL model_empty: got no pending crosswalk, expected one");
            return;
        end
        e    = '0;
        e[w] = 1'b1;
        exp_q.push_back(e);
        ped_signal = 1'b1;
        @(negedge clk);
        check("ped_req_walk", 32'(ped_req), 1);
        btn = walk_press;
        repeat (10) @(negedge clk);
        btn        = '0;
        m_pend     = m_pend | (walk_press & ~e);
        ped_signal = 1'b0;
        @(negedge clk);
        m_pend[w] = 1'b0;
`ifdef ACCESS_PRIO_EN
        if (w != 0) m_rr = (w + 1) % NX;
`else
        m_rr = (w + 1) % NX;
`endif
        check("clear_ped_req", 32'(ped_req), 0);
        check("clear_grant", 32'(walk_grant), 0);
        check("clear_wait_sat", 32'(wait_sat), 0);
        check("pending_after_walk", 32'(pending), 32'(m_pend));
    endtask

    initial begin
        logic [NX-1:0] rmask;
        int            guard;

        reset      = 1'b1;
        btn        = '0;
        ped_signal = 1'b0;
        m_pend     = '0;
        m_rr       = 0;
        #1;
        check("rst_ped_req", 32'(ped_req), 0);
        check("rst_grant", 32'(walk_grant), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_wait_sat", 32'(wait_sat), 0);
        do_reset();

        // Idle with no buttons.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ped_req", 32'(ped_req), 0);
            check("idle_pending", 32'(pending), 0);
            check("idle_grant", 32'(walk_grant), 0);
        end

        // Short glitch is filtered; a held press latches on the 7th edge.
        btn = 4'b0100;
        repeat (3) @(negedge clk);
        btn = '0;
        repeat (10) @(negedge clk);
        check("glitch_pending", 32'(pending), 0);
        btn = 4'b0100;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) check("press_k6_pending", 32'(pending), 0);
        end
        check("press_k7_pending", 32'(pending), 32'h4);
        check("press_k7_ped_req", 32'(ped_req), 0);
        @(negedge clk);
        check("press_k8_ped_req", 32'(ped_req), 1);
        btn    = '0;
        m_pend = 4'b0100;
        walk('0);

        // Round-robin over 1011 from pointer 0.
        do_reset();
        press_wait(4'b1011);
        walk('0);
        walk('0);
        walk('0);
        check("rr_pending_empty", 32'(pending), 0);

        // Wait counter saturation.
        btn = 4'b0010;
        wait_req();
        btn    = '0;
        m_pend = m_pend | 4'b0010;
        for (int j = 1; j <= 70; j++) begin
            @(negedge clk);
            if (j == 62 || j == 63 || j == 70)
                check($sformatf("wait_sat_%0d", j), 32'(wait_sat), (j >= 63) ? 1 : 0);
        end
        walk('0);

        // Reset in the middle of a walk phase.
        do_reset();
        press_wait(4'b0110);
        wait_req();
        begin
            int            w;
            logic [NX-1:0] e;
            w    = model_pick();
            e    = '0;
            e[w] = 1'b1;
            exp_q.push_back(e);
        end
        ped_signal = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_ped_req", 32'(ped_req), 0);
        check("midrst_grant", 32'(walk_grant), 0);
        check("midrst_pending", 32'(pending), 0);
        check("midrst_wait_sat", 32'(wait_sat), 0);
        ped_signal = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        m_pend = '0;
        m_rr   = 0;
        repeat (4) @(negedge clk);
        check("postrst_pending", 32'(pending), 0);
        check("postrst_ped_req", 32'(ped_req), 0);

        // Priority/round-robin ordering of 1001 with pointer at 3.
        press_wait(4'b0100);
        walk('0);
        press_wait(4'b1001);
        walk('0);
        walk('0);

        // Randomised traffic including presses during walk phases.
        for (int r = 0; r < 6; r++) begin
            rmask = NX'($urandom_range(1, (1 << NX) - 1));
            press_wait(rmask);
            guard = 0;
            while (m_pend != '0 && guard < 20) begin
                if ($urandom_range(0, 2) == 0)
                    walk(NX'($urandom_range(1, (1 << NX) - 1)));
                else
                    walk('0);
                guard++;
            end
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
